dvp_pattern_gen: RTL and testbench

//  OV5640-style DVP source: generates VSYNC/HREF/8-bit data frames in the camera pixel clock domain.

---
 rtl/dvp_pkg.sv | 12 +
 rtl/dvp_timing.sv | 70 +++++++
 rtl/dvp_pattern_gen.sv | 76 +++++++
 tb/tb_dvp_pattern_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// dvp_pkg: shared encodings for the DVP pattern generator.
// Holds the pattern modes, the RGB565 colour-bar palette and the frame FSM states.
package dvp_pkg;
   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_e;
   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_COUNT = 2'd1;
   localparam logic [1:0] MODE_SOLID = 2'd2;
   localparam logic [1:0] MODE_BLACK = 2'd3;
   // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0][15:0] BAR_COLORS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                              16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
endpackage

// File: rtl/dvp_timing.sv
// dvp_timing: frame FSM with byte/blank position and line-period counters.
// Emits the raw state plus line_active, frame_start and frame_end strobes for the output stage.
module dvp_timing
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   localparam int L  = 2 * H_ACTIVE + H_BLANK,
   localparam int HW = $clog2(L)
)(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          enable_i,
   output state_e        state_o,
   output logic [HW-1:0] hcnt_o,
   output logic          line_active_o,
   output logic          frame_start_o,
   output logic          frame_end_o
);
   localparam int VW = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

   state_e        state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d, lines_m1;
   logic          line_end, last_line;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
      end
   end

   always_comb begin
      lines_m1      = state_q == S_VSYNC  ? VW'(VSYNC_LINES - 1) :
                      state_q == S_VBACK  ? VW'(V_BACK - 1) :
                      state_q == S_ACTIVE ? VW'(V_ACTIVE - 1) : VW'(V_FRONT - 1);
      line_end      = hcnt_q == HW'(L - 1);
      last_line     = line_end && vcnt_q == lines_m1;
      frame_end_o   = state_q == S_VFRONT && last_line;
      frame_start_o = enable_i && (state_q == S_IDLE || frame_end_o);
      line_active_o = state_q == S_ACTIVE && hcnt_q < HW'(2 * H_ACTIVE);
      state_d       = state_q;
      hcnt_d        = line_end ? '0 : hcnt_q + 1'b1;
      vcnt_d        = line_end ? vcnt_q + 1'b1 : vcnt_q;
      // Counters restart on every state entry; IDLE holds them at zero.
      if (state_q == S_IDLE || last_line) begin
         hcnt_d = '0;
         vcnt_d = '0;
         case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default:  state_d = enable_i ? S_VSYNC : S_IDLE;
         endcase
      end
   end

   assign state_o = state_q;
   assign hcnt_o  = hcnt_q;
endmodule

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: OV5640-style DVP source producing RGB565 test frames.
// Latches mode/colour at frame start, muxes the pixel byte and registers every output pin.
module dvp_pattern_gen
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   localparam int HW = $clog2(2 * H_ACTIVE + H_BLANK)
)(
   input  logic        ov5640_pclk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [15:0] pix_color,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);
   state_e        state;
   logic [HW-1:0] hcnt;
   logic          line_active, frame_start, frame_end;
   logic [1:0]    mode_q;
   logic [15:0]   color_q, cnt_q, h16, px;
   logic [2:0]    bar;
   logic [7:0]    data_d, data_q;
   logic          vsync_q, href_q, done_q;

   dvp_timing #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
   ) u_timing (
      .clk_i(ov5640_pclk), .rst_ni(rst_n), .enable_i(enable), .state_o(state), .hcnt_o(hcnt),
      .line_active_o(line_active), .frame_start_o(frame_start), .frame_end_o(frame_end)
   );

   always_comb begin
      h16    = 16'(hcnt);
      bar    = 3'((h16 >> 1) / 16'(H_ACTIVE / 8));
      px     = mode_q == MODE_BLACK ? 16'h0000 : mode_q == MODE_SOLID ? color_q : BAR_COLORS[bar];
      data_d = !line_active ? 8'h00 : mode_q == MODE_COUNT ? h16[7:0] : h16[0] ? px[7:0] : px[15:8];
   end

   always_ff @(posedge ov5640_pclk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_BARS;
         color_q <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (frame_start) begin
            mode_q  <= mode;
            color_q <= pix_color;
         end
         vsync_q <= state == S_VSYNC;
         href_q  <= line_active;
         data_q  <= data_d;
         done_q  <= frame_end;
         cnt_q   <= cnt_q + 16'(frame_end);
      end
   end

   assign cam_vsync  = vsync_q;
   assign cam_href   = href_q;
   assign cam_data   = data_q;
   assign frame_done = done_q;
   assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_dvp_pattern_gen.sv
// tb_dvp_pattern_gen: directed checks of the DVP pattern generator on a shrunken frame.
// 16x3 active, 4 blank, 2/1/1 sync/back/front lines: L=36 cycles, 252 cycles per frame.
module tb_dvp_pattern_gen;
   localparam int HA = 16, VA = 3, HB = 4, VS = 2, VB = 1, VF = 1;
   localparam int L  = 2 * HA + HB;
   localparam int FR = (VS + VB + VA + VF) * L;
   localparam int A0 = (VS + VB) * L;
   localparam int N  = 512;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] pix_color = 16'h0000;
   logic        cam_vsync, cam_href, frame_done;
   logic [7:0]  cam_data;
   logic [15:0] frame_cnt;

   dvp_pattern_gen #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .ov5640_pclk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .pix_color(pix_color),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int          total = 0, bad = 0;
   logic        cap_ok;
   logic        v_a [N];
   logic        h_a [N];
   logic        fd_a [N];
   logic [7:0]  d_a [N];
   logic [15:0] fc_a [N];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   // Records N negedge samples; index 0 is the first sample with cam_vsync high.
   task automatic capture(input int chg_at, input logic [1:0] new_mode);
      int w = 0;
      while (cam_vsync !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
      while (cam_vsync !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      cap_ok = w < 2000;
      for (int i = 0; i < N; i++) begin
         if (i > 0) @(negedge clk);
         if (i == chg_at) mode = new_mode;
         v_a[i] = cam_vsync; h_a[i] = cam_href; d_a[i] = cam_data;
         fd_a[i] = frame_done; fc_a[i] = frame_cnt;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0;
      #12;
      total++; if ({cam_vsync, cam_href, frame_done} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b exp=000", {cam_vsync, cam_href, frame_done}); end
      total++; if (cam_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", cam_data); end
      total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (cam_vsync !== 1'b0) begin bad++; $display("FAIL idle_vsync got=%b exp=0", cam_vsync); end
   endtask

   task automatic test_first_vsync();
      @(negedge clk); enable = 1'b1; mode = 2'd0;
      @(posedge clk); #1;
      total++; if (cam_vsync !== 1'b0) begin bad++; $display("FAIL vsync_edge1 got=%b exp=0", cam_vsync); end
      @(posedge clk); #1;
      total++; if (cam_vsync !== 1'b1) begin bad++; $display("FAIL vsync_edge2 got=%b exp=1", cam_vsync); end
   endtask

   task automatic test_bars();
      int n = 0, r = 0, e = 0, z = 0, fd = 0;
      logic [15:0] c;
      capture(-1, 2'd0);
      total++; if (!cap_ok) begin bad++; $display("FAIL bars_timeout got=0 exp=1"); end
      for (int i = 0; i < FR; i++) begin
         n += int'(v_a[i]); fd += int'(fd_a[i]);
         if (i > 0 && h_a[i] && !h_a[i-1]) r++;
         if (!h_a[i] && d_a[i] !== 8'h00) z++;
      end
      total++; if (n != VS * L) begin bad++; $display("FAIL vsync_len got=%0d exp=%0d", n, VS * L); end
      total++; if (v_a[FR] !== 1'b1) begin bad++; $display("FAIL next_vsync got=%b exp=1", v_a[FR]); end
      total++; if (r != VA) begin bad++; $display("FAIL href_pulses got=%0d exp=%0d", r, VA); end
      total++; if ({h_a[A0-1], h_a[A0], h_a[A0+2*HA-1], h_a[A0+2*HA], h_a[A0+L]} !== 5'b01101) begin
         bad++; $display("FAIL href_edges got=%b exp=01101", {h_a[A0-1], h_a[A0], h_a[A0+2*HA-1], h_a[A0+2*HA], h_a[A0+L]}); end
      for (int k = 0; k < VA; k++)
         for (int i = 0; i < 2 * HA; i++) begin
            c = bars[i / 4];
            if (d_a[A0 + k * L + i] !== ((i % 2) != 0 ? c[7:0] : c[15:8])) e++;
         end
      total++; if (e != 0) begin bad++; $display("FAIL bar_bytes got=%0d_errors exp=0", e); end
      total++; if ({d_a[A0], d_a[A0+1], d_a[A0+4], d_a[A0+5]} !== 32'hFFFF_FFE0) begin
         bad++; $display("FAIL bar_spot got=%h exp=ffffffe0", {d_a[A0], d_a[A0+1], d_a[A0+4], d_a[A0+5]}); end
      total++; if (d_a[A0+30] !== 8'h00) begin bad++; $display("FAIL bar_black got=%h exp=00", d_a[A0+30]); end
      total++; if (z != 0) begin bad++; $display("FAIL bars_blank got=%0d_nonzero exp=0", z); end
      total++; if (fd != 1 || fd_a[FR-1] !== 1'b1) begin bad++; $display("FAIL done_pulse got=%0d/%b exp=1/1", fd, fd_a[FR-1]); end
      total++; if ({fc_a[FR-2], fc_a[FR-1]} !== {16'd1, 16'd2}) begin bad++; $display("FAIL cnt_step got=%0d,%0d exp=1,2", fc_a[FR-2], fc_a[FR-1]); end
   endtask

   task automatic test_solid();
      int e = 0, z = 0;
      mode = 2'd2; pix_color = 16'hA5C3;
      capture(-1, 2'd2);
      total++; if (!cap_ok) begin bad++; $display("FAIL solid_timeout got=0 exp=1"); end
      for (int k = 0; k < VA; k++)
         for (int i = 0; i < 2 * HA; i++)
            if (d_a[A0 + k * L + i] !== ((i % 2) != 0 ? 8'hC3 : 8'hA5)) e++;
      for (int i = 0; i < FR; i++) if (!h_a[i] && d_a[i] !== 8'h00) z++;
      total++; if (e != 0) begin bad++; $display("FAIL solid_bytes got=%0d_errors exp=0", e); end
      total++; if (z != 0) begin bad++; $display("FAIL solid_blank got=%0d_nonzero exp=0", z); end
      total++; if (fc_a[FR-1] !== 16'd5) begin bad++; $display("FAIL solid_cnt got=%0d exp=5", fc_a[FR-1]); end
   endtask

   task automatic test_counter_latch();
      int e = 0;
      mode = 2'd1;
      capture(A0 + L + 6, 2'd2);
      total++; if (!cap_ok) begin bad++; $display("FAIL count_timeout got=0 exp=1"); end
      for (int k = 0; k < VA; k++)
         for (int i = 0; i < 2 * HA; i++)
            if (d_a[A0 + k * L + i] !== 8'(i)) e++;
      total++; if (e != 0) begin bad++; $display("FAIL count_bytes got=%0d_errors exp=0", e); end
      total++; if ({d_a[FR+A0], d_a[FR+A0+1]} !== 16'hA5C3) begin bad++; $display("FAIL latch_next got=%h exp=a5c3", {d_a[FR+A0], d_a[FR+A0+1]}); end
      total++; if ({fc_a[FR-1], fc_a[2*FR-1]} !== {16'd8, 16'd9}) begin bad++; $display("FAIL count_cnt got=%0d,%0d exp=8,9", fc_a[FR-1], fc_a[2*FR-1]); end
   endtask

   task automatic test_enable_drop();
      int w = 0, hc = 0, fd = 0, vc = 0;
      while (cam_href !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
      total++; if (w >= 1000) begin bad++; $display("FAIL drop_wait got=%0d exp=<1000", w); end
      enable = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         hc += int'(cam_href); fd += int'(frame_done); vc += int'(cam_vsync);
      end
      total++; if (hc != 2 * HA * VA - 1) begin bad++; $display("FAIL drop_href got=%0d exp=%0d", hc, 2 * HA * VA - 1); end
      total++; if (fd != 1) begin bad++; $display("FAIL drop_done got=%0d exp=1", fd); end
      total++; if (vc != 0) begin bad++; $display("FAIL drop_vsync got=%0d exp=0", vc); end
      total++; if (frame_cnt !== 16'd10) begin bad++; $display("FAIL drop_cnt got=%0d exp=10", frame_cnt); end
      total++; if ({cam_href, cam_data} !== 9'd0) begin bad++; $display("FAIL drop_idle got=%h exp=000", {cam_href, cam_data}); end
   endtask

   task automatic test_reset_midline();
      int w = 0, n = 0, hc = 0, e = 0;
      @(negedge clk); enable = 1'b1;
      while (cam_href !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
      repeat (3) @(negedge clk);
      total++; if (cam_href !== 1'b1) begin bad++; $display("FAIL pre_rst_href got=%b exp=1", cam_href); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({cam_vsync, cam_href, frame_done, cam_data, frame_cnt} !== 27'd0) begin
         bad++; $display("FAIL async_rst got=%h exp=0", {cam_vsync, cam_href, frame_done, cam_data, frame_cnt}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (cam_vsync !== 1'b0) begin bad++; $display("FAIL rst_edge1 got=%b exp=0", cam_vsync); end
      capture(-1, 2'd2);
      total++; if (!cap_ok) begin bad++; $display("FAIL rst_timeout got=0 exp=1"); end
      for (int i = 0; i < FR; i++) begin n += int'(v_a[i]); hc += int'(h_a[i]); end
      for (int i = 0; i < 2 * HA; i++) if (d_a[A0 + i] !== ((i % 2) != 0 ? 8'hC3 : 8'hA5)) e++;
      total++; if (n != VS * L || hc != 2 * HA * VA) begin bad++; $display("FAIL rst_frame got=%0d/%0d exp=%0d/%0d", n, hc, VS * L, 2 * HA * VA); end
      total++; if (e != 0) begin bad++; $display("FAIL rst_bytes got=%0d_errors exp=0", e); end
      total++; if ({fc_a[FR-2], fc_a[FR-1]} !== {16'd0, 16'd1}) begin bad++; $display("FAIL rst_cnt got=%0d,%0d exp=0,1", fc_a[FR-2], fc_a[FR-1]); end
   endtask

   initial begin
      test_reset();
      test_first_vsync();
      test_bars();
      test_solid();
      test_counter_latch();
      test_enable_drop();
      test_reset_midline();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
